// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the mips_cpu_bus two-master arbiter.
package mips_bus_pkg;

   localparam int          ADDR_W_DEF   = 32;
   localparam int          DATA_W_DEF   = 32;
   localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      RESP
   } arb_state_t;

endpackage

// File: rtl/mips_bus_rr_pick.sv
// Combinational two-way round-robin picker: on a tie the master that did not
// own the bus last wins.
module mips_bus_rr_pick
   import mips_bus_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_owner_i,
   output logic       valid_o,
   output logic       winner_o
);

   always_comb begin
      valid_o  = |req_i;
      winner_o = (req_i == 2'b11) ? ~last_owner_i : req_i[1];
   end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-master, one-slave arbiter for the mips_cpu_bus memory interface with
// registered round-robin grant, read-data return strobe and a stall timeout.
module mips_bus_arbiter
   import mips_bus_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   output logic [ADDR_W-1:0]   s_address,
   output logic                s_read,
   output logic                s_write,
   output logic [DATA_W-1:0]   s_writedata,
   output logic [DATA_W/8-1:0] s_byteenable,
   input  logic                s_waitrequest,
   input  logic [DATA_W-1:0]   s_readdata,
   output logic                timeout_err
);

   localparam int            TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

   arb_state_t          state_q, state_d;
   logic                owner_q, owner_d;
   logic                last_owner_q, last_owner_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
   logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;

   logic                pick_valid, pick_winner;
   logic                own_read, own_write, accept;
   logic [ADDR_W-1:0]   own_address;
   logic [DATA_W-1:0]   own_writedata;
   logic [DATA_W/8-1:0] own_byteenable;

   mips_bus_rr_pick u_pick (
      .req_i        ({m1_read | m1_write, m0_read | m0_write}),
      .last_owner_i (last_owner_q),
      .valid_o      (pick_valid),
      .winner_o     (pick_winner)
   );

   always_comb begin
      own_read       = owner_q ? m1_read       : m0_read;
      own_write      = owner_q ? m1_write      : m0_write;
      own_address    = owner_q ? m1_address    : m0_address;
      own_writedata  = owner_q ? m1_writedata  : m0_writedata;
      own_byteenable = owner_q ? m1_byteenable : m0_byteenable;
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latches).
      state_d          = state_q;
      owner_d          = owner_q;
      last_owner_d     = last_owner_q;
      timer_d          = '0;
      err_d            = err_q;
      m0_rdata_d       = m0_rdata_q;
      m1_rdata_d       = m1_rdata_q;
      accept           = 1'b0;
      s_address        = own_address;
      s_writedata      = own_writedata;
      s_byteenable     = own_byteenable;
      s_read           = 1'b0;
      s_write          = 1'b0;
      m0_waitrequest   = 1'b1;
      m1_waitrequest   = 1'b1;
      m0_readdatavalid = 1'b0;
      m1_readdatavalid = 1'b0;
      m0_readdata      = m0_rdata_q;
      m1_readdata      = m1_rdata_q;

      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d = GRANT;
               owner_d = pick_winner;
            end
         end
         GRANT: begin
            // A simultaneous read+write request is treated as a write.
            s_write = own_write;
            s_read  = own_read & ~own_write;
            if (owner_q) m1_waitrequest = s_waitrequest;
            else         m0_waitrequest = s_waitrequest;
            accept = (s_read | s_write) & ~s_waitrequest;
            if (accept) begin
               last_owner_d = owner_q;
               state_d      = s_write ? IDLE : RESP;
            end else if (!(own_read | own_write)) begin
               state_d = IDLE;
            end else begin
               timer_d = (timer_q == TMAX) ? timer_q : timer_q + TW'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
            if (owner_q) begin
               m1_readdata      = s_readdata;
               m1_readdatavalid = 1'b1;
               m1_rdata_d       = s_readdata;
            end else begin
               m0_readdata      = s_readdata;
               m0_readdatavalid = 1'b1;
               m0_rdata_d       = s_readdata;
            end
         end
         default: state_d = IDLE;
      endcase

      if (TIMEOUT != 0 && timer_d == TMAX) err_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         timer_q      <= '0;
         err_q        <= 1'b0;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         timer_q      <= timer_d;
         err_q        <= err_d;
         m0_rdata_q   <= m0_rdata_d;
         m1_rdata_q   <= m1_rdata_d;
      end
   end

   assign timeout_err = err_q;

endmodule
